// File: rtl/lcd_frame_ctrl.sv
// HD44780-class character LCD controller with an internal ROWS x COLS frame buffer.
// Writers update characters at (row,col); only dirty rows are re-sent with self-timed E strobes.
module lcd_frame_ctrl #(
  parameter  int COLS      = 16,
  parameter  int ROWS      = 2,
  parameter  int SETUP_CYC = 2,
  parameter  int PULSE_CYC = 4,
  parameter  int HOLD_CYC  = 50,
  parameter  int CLR_CYC   = 2000,
  parameter  int PWRUP_CYC = 20000,
  localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CLW       = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_valid,
  output logic           wr_ready,
  input  logic [RW-1:0]  wr_row,
  input  logic [CLW-1:0] wr_col,
  input  logic [7:0]     wr_char,
  input  logic           clr_req,
  output logic           busy,
  output logic           LCD_E,
  output logic           LCD_RS,
  output logic           LCD_RW,
  output logic [7:0]     LCD_DATA
);

  localparam int NENT = ROWS * COLS;
  localparam int AW   = (NENT > 1) ? $clog2(NENT) : 1;
  localparam int IW   = $clog2(NENT + 4);
  localparam int M1   = (PWRUP_CYC > CLR_CYC) ? PWRUP_CYC : CLR_CYC;
  localparam int M2   = (HOLD_CYC > PULSE_CYC) ? HOLD_CYC : PULSE_CYC;
  localparam int M3   = (M2 > SETUP_CYC) ? M2 : SETUP_CYC;
  localparam int MAXC = (M1 > M3) ? M1 : M3;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {S_FILL, S_PWRUP, S_INIT, S_IDLE, S_ADDR, S_CHAR} state_t;
  typedef enum logic [1:0] {P_IDLE, P_SETUP, P_PULSE, P_HOLD} phase_t;

  state_t          r_state, w_state_nxt;
  phase_t          r_phase;
  logic [CW-1:0]   r_cnt;
  logic [IW-1:0]   r_idx;
  logic [RW-1:0]   r_row;
  logic [ROWS-1:0] r_dirty;
  logic            r_clr_pend, r_boot, r_e, r_rs;
  logic [7:0]      r_data;
  logic [7:0]      r_buf [NENT];

  logic            w_start, w_tx_rs, w_tx_done, w_fill_last, w_pick, w_wr_ok;
  logic [7:0]      w_tx_data, w_base;
  logic [RW-1:0]   w_pick_row;
  logic [AW-1:0]   w_wr_addr, w_rd_addr;

  assign w_wr_ok     = wr_valid && wr_ready && (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);
  assign w_wr_addr   = AW'(int'(wr_row) * COLS + int'(wr_col));
  assign w_rd_addr   = AW'(int'(r_row) * COLS + int'(r_idx));
  assign w_fill_last = (r_state == S_FILL) && (r_idx == IW'(NENT - 1));
  assign w_tx_done   = (r_phase == P_HOLD) && (r_cnt == '0);
  // DDRAM row bases: 0x00, 0x40, COLS, 0x40+COLS
  assign w_base      = 8'(((int'(r_row) % 2) * 64) + ((int'(r_row) / 2) * COLS));

  assign wr_ready = (r_state != S_FILL);
  assign busy     = (r_state != S_IDLE) || (|r_dirty) || r_clr_pend;
  assign LCD_E    = r_e;
  assign LCD_RS   = r_rs;
  assign LCD_RW   = 1'b0;
  assign LCD_DATA = r_data;

  always_comb begin
    w_pick_row = '0;
    for (int i = ROWS - 1; i >= 0; i--)
      if (r_dirty[i]) w_pick_row = RW'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FILL;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_tx_rs     = 1'b0;
    w_tx_data   = 8'h00;
    w_pick      = 1'b0;
    unique case (r_state)
      S_FILL:  if (w_fill_last) w_state_nxt = r_boot ? S_PWRUP : S_IDLE;
      S_PWRUP: if (r_cnt == '0) w_state_nxt = S_INIT;
      S_INIT: begin
        w_start = (r_phase == P_IDLE);
        case (r_idx[1:0])
          2'd0:    w_tx_data = 8'h38;
          2'd1:    w_tx_data = 8'h0C;
          2'd2:    w_tx_data = 8'h06;
          default: w_tx_data = 8'h01;
        endcase
        if (w_tx_done && r_idx == IW'(3)) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        // a pending clear outranks dirty rows and skips the 0x01 command
        if (r_clr_pend || clr_req) w_state_nxt = S_FILL;
        else if (|r_dirty) begin
          w_pick      = 1'b1;
          w_state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        w_start   = (r_phase == P_IDLE);
        w_tx_data = 8'h80 | w_base;
        if (w_tx_done) w_state_nxt = S_CHAR;
      end
      S_CHAR: begin
        w_start   = (r_phase == P_IDLE);
        w_tx_rs   = 1'b1;
        w_tx_data = r_buf[w_rd_addr];
        if (w_tx_done && r_idx == IW'(COLS - 1)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (r_state == S_FILL) r_buf[r_idx[AW-1:0]] <= 8'h20;
    else if (w_wr_ok)      r_buf[w_wr_addr]     <= wr_char;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase    <= P_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_row      <= '0;
      r_dirty    <= '0;
      r_clr_pend <= 1'b0;
      r_boot     <= 1'b1;
      r_e        <= 1'b0;
      r_rs       <= 1'b0;
      r_data     <= 8'h00;
    end else begin
      if (r_state != w_state_nxt)               r_idx <= '0;
      else if (r_state == S_FILL || w_tx_done) r_idx <= r_idx + IW'(1);

      if (w_pick)      r_row  <= w_pick_row;
      if (w_fill_last) r_boot <= 1'b0;

      if (r_state == S_IDLE) r_clr_pend <= 1'b0;
      else if (clr_req)      r_clr_pend <= 1'b1;

      // later assignment wins: a write re-dirties a row cleared on the same edge
      if (w_fill_last) r_dirty <= '1;
      else begin
        if (w_pick)  r_dirty[w_pick_row] <= 1'b0;
        if (w_wr_ok) r_dirty[wr_row]     <= 1'b1;
      end

      if (w_start) begin
        r_phase <= P_SETUP;
        r_cnt   <= CW'(SETUP_CYC - 1);
        r_rs    <= w_tx_rs;
        r_data  <= w_tx_data;
      end else begin
        case (r_phase)
          P_SETUP:
            if (r_cnt == '0) begin
              r_phase <= P_PULSE;
              r_e     <= 1'b1;
              r_cnt   <= CW'(PULSE_CYC - 1);
            end else r_cnt <= r_cnt - CW'(1);
          P_PULSE:
            if (r_cnt == '0) begin
              r_phase <= P_HOLD;
              r_e     <= 1'b0;
              r_cnt   <= (!r_rs && r_data == 8'h01) ? CW'(CLR_CYC - 1) : CW'(HOLD_CYC - 1);
            end else r_cnt <= r_cnt - CW'(1);
          P_HOLD:
            if (r_cnt == '0) r_phase <= P_IDLE;
            else             r_cnt   <= r_cnt - CW'(1);
          P_IDLE:
            // the idle counter doubles as the power-up delay
            if (w_fill_last && r_boot)                 r_cnt <= CW'(PWRUP_CYC - 1);
            else if (r_state == S_PWRUP && r_cnt != '0) r_cnt <= r_cnt - CW'(1);
        endcase
      end
    end
  end

endmodule
